// File: rtl/scale_mux_arb.sv
// rtl/scale_mux_arb.sv - two-channel buffered round-robin input stage for a 2:1 scale mux
module scale_mux_arb #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic [WIDTH-1:0] mux_a,
  output logic [WIDTH-1:0] mux_b,
  output logic             sel_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
);

  typedef enum logic [1:0] {IDLE, OFFER_A, OFFER_B} state_t;

  state_t           state;
  state_t           state_nx;
  logic             a_full;
  logic             b_full;
  logic [WIDTH-1:0] a_buf;
  logic [WIDTH-1:0] b_buf;
  logic             last_b;
  logic             sel_q;

  logic fire;
  logic a_load;
  logic b_load;
  logic a_clr;
  logic b_clr;
  logic a_full_nx;
  logic b_full_nx;
  logic last_b_nx;

  // Ready is a pure register decode so upstream never sees a path from out_ready.
  assign a_ready   = !a_full;
  assign b_ready   = !b_full;
  assign mux_a     = a_buf;
  assign mux_b     = b_buf;
  assign out_valid = (state != IDLE);
  // Select follows the offered channel; in IDLE it keeps the last grant.
  assign sel_a     = (state == OFFER_A) ? 1'b1 :
                     (state == OFFER_B) ? 1'b0 : sel_q;

  assign fire      = out_valid && out_ready;
  assign a_clr     = fire && (state == OFFER_A);
  assign b_clr     = fire && (state == OFFER_B);
  assign a_load    = a_valid && !a_full;
  assign b_load    = b_valid && !b_full;
  // A load can only happen into an empty buffer, and a clear only on a full one,
  // so the two never target the same buffer in one edge.
  assign a_full_nx = a_load || (a_full && !a_clr);
  assign b_full_nx = b_load || (b_full && !b_clr);
  assign last_b_nx = a_clr ? 1'b0 : (b_clr ? 1'b1 : last_b);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel_q <= 1'b0;
    end else begin
      state <= state_nx;
      sel_q <= sel_a;
    end
  end

  // Next grant decided from post-edge buffer status; an unaccepted offer is held.
  always_comb begin
    state_nx = state;
    if ((state == IDLE) || fire) begin
      if (a_full_nx && b_full_nx) begin
        state_nx = last_b_nx ? OFFER_A : OFFER_B;
      end else if (a_full_nx) begin
        state_nx = OFFER_A;
      end else if (b_full_nx) begin
        state_nx = OFFER_B;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  // Single-entry buffers and the last-served pointer (B after reset so A wins the first tie).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_full <= 1'b0;
      b_full <= 1'b0;
      a_buf  <= '0;
      b_buf  <= '0;
      last_b <= 1'b1;
    end else begin
      a_full <= a_full_nx;
      b_full <= b_full_nx;
      last_b <= last_b_nx;
      if (a_load) a_buf <= a_data;
      if (b_load) b_buf <= b_data;
    end
  end

  // Saturating per-channel transfer counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (a_clr && (a_cnt != {CNT_W{1'b1}})) a_cnt <= a_cnt + CNT_W'(1);
      if (b_clr && (b_cnt != {CNT_W{1'b1}})) b_cnt <= b_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_scale_mux_arb.sv
// tb/tb_scale_mux_arb.sv - scoreboard bench for scale_mux_arb
module tb_scale_mux_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid, out_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, sel_a, out_valid;
  logic [7:0] mux_a, mux_b, a_cnt, b_cnt;

  logic       s_rst_n;
  logic       s_a_valid, s_b_valid, s_out_ready;
  logic [7:0] s_a_data, s_b_data;
  logic       s_a_ready, s_b_ready, s_sel_a, s_out_valid;
  logic [7:0] s_mux_a, s_mux_b;
  logic [1:0] s_a_cnt, s_b_cnt;

  typedef struct {
    logic       sel;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  scale_mux_arb #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .mux_a(mux_a), .mux_b(mux_b), .sel_a(sel_a),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_cnt(a_cnt), .b_cnt(b_cnt)
  );

  scale_mux_arb #(.WIDTH(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(s_rst_n),
    .a_valid(s_a_valid), .a_data(s_a_data), .a_ready(s_a_ready),
    .b_valid(s_b_valid), .b_data(s_b_data), .b_ready(s_b_ready),
    .mux_a(s_mux_a), .mux_b(s_mux_b), .sel_a(s_sel_a),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .a_cnt(s_a_cnt), .b_cnt(s_b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every word that will fire on the next edge is popped and compared.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_sel", sel_a, e.sel);
        chk("sb_data", sel_a ? mux_a : mux_b, e.data);
      end
    end
  end

  task automatic push(input logic s, input logic [7:0] d);
    exp_t e;
    e.sel = s;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = '0; b_data = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_a(input logic [7:0] d);
    int n = 0;
    a_valid = 1'b1;
    a_data = d;
    @(negedge clk);
    while (!a_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("a_accept_timeout", n < 50, 1);
    @(posedge clk);
    #1 a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    int n = 0;
    b_valid = 1'b1;
    b_data = d;
    @(negedge clk);
    while (!b_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b_accept_timeout", n < 50, 1);
    @(posedge clk);
    #1 b_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    s_rst_n = 1'b0;
    s_a_valid = 1'b0; s_b_valid = 1'b0; s_out_ready = 1'b1;
    s_a_data = '0; s_b_data = '0;

    // Reset and idle
    do_reset();
    s_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_a_ready", a_ready, 1);
      chk("rst_b_ready", b_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sel_a", sel_a, 0);
      chk("rst_cnt", {a_cnt, b_cnt}, 0);
    end

    // Single A word
    @(posedge clk);
    #1 out_ready = 1'b1;
    push(1'b1, 8'h3C);
    send_a(8'h3C);
    @(negedge clk);
    chk("single_valid", out_valid, 1);
    chk("single_sel", sel_a, 1);
    chk("single_mux_a", mux_a, 8'h3C);
    @(negedge clk);
    chk("single_cnt", a_cnt, 1);
    chk("single_idle", out_valid, 0);
    chk("single_a_ready", a_ready, 1);

    // Simultaneous A and B: A wins the first tie
    do_reset();
    out_ready = 1'b1;
    push(1'b1, 8'h11);
    push(1'b0, 8'h22);
    a_valid = 1'b1; a_data = 8'h11;
    b_valid = 1'b1; b_data = 8'h22;
    @(posedge clk);
    #1 a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    chk("tie_first_sel", sel_a, 1);
    @(negedge clk);
    chk("tie_second_sel", sel_a, 0);
    drain();
    chk("tie_a_cnt", a_cnt, 1);
    chk("tie_b_cnt", b_cnt, 1);

    // Both channels streaming: grants alternate A,B,...
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(1'b1, 8'hA0 + 8'(i));
      push(1'b0, 8'hB0 + 8'(i));
    end
    fork
      for (int i = 0; i < 10; i++) send_a(8'hA0 + 8'(i));
      for (int j = 0; j < 10; j++) send_b(8'hB0 + 8'(j));
    join
    drain();
    chk("stream_a_cnt", a_cnt, 10);
    chk("stream_b_cnt", b_cnt, 10);

    // Backpressure: A held while B fills
    do_reset();
    push(1'b1, 8'h5A);
    push(1'b0, 8'h6B);
    send_a(8'h5A);
    send_b(8'h6B);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_sel", sel_a, 1);
      chk("bp_mux_a", mux_a, 8'h5A);
      chk("bp_a_ready", a_ready, 0);
      chk("bp_b_ready", b_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_b_next_valid", out_valid, 1);
    chk("bp_b_next_sel", sel_a, 0);
    drain();
    chk("bp_a_cnt", a_cnt, 1);
    chk("bp_b_cnt", b_cnt, 1);

    // Saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 s_a_valid = 1'b1; s_a_data = 8'(i);
      @(posedge clk);
      #1 s_a_valid = 1'b0;
      @(negedge clk);
      chk("sat_offer", s_out_valid, 1);
      @(negedge clk);
      chk("sat_a_cnt", s_a_cnt, (i + 1 > 3) ? 3 : i + 1);
    end

    // Asynchronous reset mid-offer
    s_out_ready = 1'b0;
    @(posedge clk);
    #1 s_a_valid = 1'b1; s_a_data = 8'h77;
    @(posedge clk);
    #1 s_a_valid = 1'b0;
    @(negedge clk);
    chk("mid_offer", s_out_valid, 1);
    #2 s_rst_n = 1'b0;
    #1;
    chk("async_out_valid", s_out_valid, 0);
    chk("async_a_cnt", s_a_cnt, 0);
    chk("async_a_ready", s_a_ready, 1);
    chk("async_b_ready", s_b_ready, 1);
    @(posedge clk);
    #1 s_rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", s_out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scale_mux_arb.md
Name: scale_mux_arb

Overview:
- Two-channel input stage that sits directly upstream of the team's parameterized 2:1 scale mux.
- Accepts two independent valid/ready data streams (A and B) and holds each in a single-entry buffer.
- Arbitrates round-robin between full buffers.
- Drives the mux data inputs and select, and presents a valid/ready handshake for the mux's output consumer, plus per-channel transfer counters.

Parameters:
- WIDTH, 8, data width of both channels and of the mux data inputs.
- CNT_W, 8, width of each saturating transfer counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_valid  input  1  channel A source has data.
- a_data  input  WIDTH  channel A data.
- a_ready  output  1  channel A buffer empty, can accept.
- b_valid  input  1  channel B source has data.
- b_data  input  WIDTH  channel B data.
- b_ready  output  1  channel B buffer empty, can accept.
- mux_a  output  WIDTH  channel A buffer contents, to mux in_a.
- mux_b  output  WIDTH  channel B buffer contents, to mux in_b.
- sel_a  output  1  mux select: 1 = A offered, 0 = B offered.
- out_valid  output  1  selected buffer is being offered downstream.
- out_ready  input  1  downstream accepts the offered word.
- a_cnt  output  CNT_W  completed A output transfers, saturating.
- b_cnt  output  CNT_W  completed B output transfers, saturating.

Behaviour:
- Reset (async on rst_n low, held while low):
  - both buffers empty; buffer data 0; state IDLE; sel_a 0; out_valid 0.
  - last-served pointer = B, so A wins the first tie.
  - a_cnt = b_cnt = 0.
  - a_ready = b_ready = 1, since both are derived from the empty buffers.
- Input handshake:
  - x_ready = !x_full, a pure register decode with no combinational path from out_ready.
  - Accept on x_valid && x_ready at a rising edge: buffer loads x_data and x_full is set.
  - Each channel therefore sustains at most 1 word per 2 cycles.
- Output handshake:
  - Fire = out_valid && out_ready at a rising edge.
  - On fire, the granted buffer is cleared, its counter increments, and the last-served pointer takes the granted channel.
- State machine (states IDLE, OFFER_A, OFFER_B); outputs are decodes of the state register:
  - out_valid = (state != IDLE).
  - sel_a = 1 in OFFER_A, 0 in OFFER_B; in IDLE it holds its last value.
- Next-state rule, evaluated every edge using the post-edge buffer status (including a load and/or clear in the same edge):
  - In OFFER_X without fire: hold OFFER_X. The grant never changes while offered and unaccepted, and buffer X cannot change because x_ready = 0.
  - In OFFER_X with fire, or in IDLE:
    - if both buffers will be full, offer the channel other than last-served;
    - else if exactly one will be full, offer it;
    - else go to IDLE.
- Latency:
  - A word accepted at edge N is offered (out_valid = 1) in the cycle after edge N, provided no other offer is pending.
  - A word may be accepted into the buffer the same edge the other channel fires.
- Round-robin: with both channels continuously full, grants alternate A, B, A, B. There is no starvation.
- mux_a and mux_b always reflect buffer contents. Stale data remains after a clear; it is only meaningful when selected and out_valid = 1.
- Counters: increment by 1 on fire of their channel and saturate at 2^CNT_W-1 (no wrap).
- Reset mid-operation: all state is discarded immediately (async). Pending buffered words are lost and not counted.
- The upstream source must not change x_data while x_valid && !x_ready (standard valid/ready stability). The block does not check this.

Test Plan:
- Reset then idle → a_ready = b_ready = 1, out_valid = 0, sel_a = 0, a_cnt = b_cnt = 0 for 5 cycles.
- Single A word 0x3C accepted at edge 1, out_ready = 1 → out_valid = 1 and sel_a = 1 in cycle 2, mux_a = 0x3C; fire at edge 2; a_cnt = 1; out_valid = 0 in cycle 3; a_ready = 1 in cycle 3.
- A = 0x11 and B = 0x22 accepted the same edge, out_ready = 1 → offers 0x11 (A, first tie) then 0x22 (B) on consecutive cycles; a_cnt = b_cnt = 1.
- Both channels streaming for 20 offers, out_ready = 1 → sel_a alternates 1,0,1,0…; a_cnt = b_cnt = 10.
- Backpressure: A offered with out_ready = 0 for 4 cycles while B fills → sel_a stays 1, mux_a stable, a_ready = 0, b_ready = 0 once B is full; release out_ready → A fires, B is offered next cycle.
- Saturation with CNT_W = 2: 5 A transfers → a_cnt sequence 1, 2, 3, 3, 3. Then rst_n pulsed low mid-offer → out_valid drops asynchronously, counters return to 0, buffers empty.
